// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and sizing helper for the SPI master
package spi_pkg;

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} spi_state_t;

  // Edge counter must hold every edge number 0..2*data_w
  function automatic int edge_cnt_w(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCK divider: tick every D clk cycles, registered sck with idle level load
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             run,
  input  logic             load_idle,
  input  logic             cpol,
  input  logic             toggle,
  output logic             tick,
  output logic             sck
);

  logic [DIV_W-1:0] reload;
  logic [DIV_W-1:0] cnt;

  assign tick = run && (cnt == '0);

  // A divider of 0 behaves as 1, so the reload value saturates at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      reload <= '0;
      cnt    <= '0;
    end else if (restart) begin
      reload <= (clk_div == '0) ? '0 : clk_div - DIV_W'(1);
      cnt    <= (clk_div == '0) ? '0 : clk_div - DIV_W'(1);
    end else if (tick) begin
      cnt <= reload;
    end else if (cnt != '0) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck <= 1'b0;
    end else if (load_idle) begin
      sck <= cpol;
    end else if (toggle) begin
      sck <= ~sck;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised full-duplex SPI master (optional SPI_LOOPBACK_EN internal loopback)
module spi_master_param
  import spi_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  NUM_SS = 4,
  parameter int  DIV_W  = 8,
  localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [NUM_SS-1:0] ss_n
);

  localparam int EW = edge_cnt_w(DATA_W);

  spi_state_t        state, next_state;
  logic              accept, tick, run, load_idle, toggle;
  logic              sample_now, shift_now, last_edge, sample_bit;
  logic [EW-1:0]     edge_cnt, edge_num;
  logic              cpha_q, lsb_q;
  logic [DATA_W-1:0] tx_sr, rx_sr;

  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
    for (int i = 0; i < NUM_SS; i++) begin
      ss_decode[i] = (32'(sel) != i);
    end
  endfunction

`ifdef SPI_LOOPBACK_EN
  assign sample_bit = loopback ? mosi : miso;
`else
  assign sample_bit = miso;
`endif

  assign run       = (state == LEAD) || (state == XFER) || (state == TRAIL);
  assign busy      = run;
  assign done      = (state == DONE);
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign load_idle = (state == IDLE) || accept;
  assign toggle    = (state == XFER) && tick;
  assign edge_num  = edge_cnt + EW'(1);
  assign last_edge = (edge_num == EW'(2 * DATA_W));

  // Odd edges sample when cpha=0, even edges when cpha=1; shifting uses the other parity
  assign sample_now = toggle && (edge_num[0] != cpha_q);
  assign shift_now  = toggle && (edge_num[0] == cpha_q) &&
                      (cpha_q ? (edge_num >= EW'(3)) : (edge_num <= EW'(2 * DATA_W - 2)));

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .restart   (accept),
    .clk_div   (clk_div),
    .run       (run),
    .load_idle (load_idle),
    .cpol      (cpol),
    .toggle    (toggle),
    .tick      (tick),
    .sck       (sck)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LEAD;
      LEAD:    if (tick) next_state = XFER;
      XFER:    if (tick && last_edge) next_state = TRAIL;
      TRAIL:   if (tick) next_state = DONE;
      DONE:    next_state = start ? LEAD : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      mosi     <= 1'b0;
      ss_n     <= '1;
      edge_cnt <= '0;
    end else begin
      if (accept) begin
        cpha_q   <= cpha;
        lsb_q    <= lsb_first;
        tx_sr    <= tx_data;
        rx_sr    <= '0;
        mosi     <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
        ss_n     <= ss_decode(ss_sel);
        edge_cnt <= '0;
      end
      if (toggle) begin
        edge_cnt <= last_edge ? '0 : edge_num;
      end
      if (sample_now) begin
        rx_sr <= lsb_q ? {sample_bit, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], sample_bit};
      end
      if (shift_now) begin
        tx_sr <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
        mosi  <= lsb_q ? tx_sr[1] : tx_sr[DATA_W-2];
      end
      if ((state == TRAIL) && tick) begin
        ss_n    <= '1;
        rx_data <= rx_sr;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - self-checking bench: directed table, random transfers, corner sequences
module tb_spi_master_param;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] tx_data = '0, clk_div = 8'd1, rx_data;
  logic [1:0] ss_sel = '0;
  logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic       busy, done, sck, mosi, miso;
  logic [2:0] ss_n;
  logic       ext_loop = 1'b0, slave_bit = 1'b0;
  int         tests = 0, fails = 0;

  assign miso = ext_loop ? mosi : slave_bit;
  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(8), .NUM_SS(3), .DIV_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .ss_sel(ss_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
    .busy(busy), .done(done), .rx_data(rx_data), .sck(sck), .mosi(mosi), .miso(miso),
`ifdef SPI_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .ss_n(ss_n)
  );

  typedef struct {
    logic cpol, cpha, lsb;
    logic [7:0] div, tx, slv;
    logic [1:0] sel;
    logic ext;
    logic [7:0] exp_rx;
    int exp_lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic cp, input logic ph, input logic lsb, input logic [7:0] div,
                              input logic [7:0] tx, input logic [7:0] slv, input logic [1:0] sel,
                              input logic ext, input logic [7:0] exp_rx, input int exp_lat);
    vec_t v;
    v.cpol = cp; v.cpha = ph; v.lsb = lsb; v.div = div; v.tx = tx; v.slv = slv;
    v.sel = sel; v.ext = ext; v.exp_rx = exp_rx; v.exp_lat = exp_lat;
    return v;
  endfunction

  // Word-level reference: rx is the slave word (or own tx when looped/unselected), fixed frame length
  function automatic vec_t model(input vec_t v);
    int d;
    d = (v.div == 8'd0) ? 1 : int'(v.div);
    v.exp_rx  = (v.ext || v.sel > 2'd2) ? v.tx : v.slv;
    v.exp_lat = 1 + d * (2 * 8 + 2);
    return v;
  endfunction

  function automatic logic bit_of(input logic [7:0] w, input logic lsb, input int j);
    return lsb ? w[j] : w[7-j];
  endfunction

  task automatic run_xfer(input vec_t v, input bit poke, input bit chain, input string tag);
    int c, e, nrx, lat, low_cnt, bad_cnt, rises, j;
    logic [7:0] srx;
    logic [2:0] mask;
    bit valid, sel_low, prev_sel, prev_sck;
    valid = (v.sel < 2'd3);
    mask  = valid ? ~(3'b001 << v.sel) : 3'b111;
    e = 0; nrx = 0; lat = 0; low_cnt = 0; bad_cnt = 0; rises = 0; srx = '0;
    @(negedge clk);
    ext_loop = v.ext || !valid; slave_bit = 1'b0;
    cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb; clk_div = v.div;
    tx_data = v.tx; ss_sel = v.sel;
    @(negedge clk);
    chk({tag, " idle_sck"}, sck, v.cpol);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev_sck = v.cpol; prev_sel = 1'b0;
    for (c = 1; c <= 200; c++) begin
      if (c == 1) chk({tag, " first_mosi"}, mosi, bit_of(v.tx, v.lsb, 0));
      if (poke && c == 4) begin
        start = 1'b1; tx_data = ~v.tx; cpol = ~v.cpol; cpha = ~v.cpha;
        lsb_first = ~v.lsb; clk_div = 8'd5; ss_sel = v.sel + 2'd1;
      end
      if (poke && c == 5) start = 1'b0;
      sel_low = valid && (ss_n == mask);
      if (ss_n != 3'b111) low_cnt++;
      if (ss_n != 3'b111 && ss_n != mask) bad_cnt++;
      if (sck && !prev_sck) rises++;
      if (sel_low && !prev_sel) begin
        e = 0;
        if (!v.cpha) slave_bit = bit_of(v.slv, v.lsb, 0);
      end else if (sel_low && sck != prev_sck) begin
        e++;
        if (((e % 2) == 1) != v.cpha) begin
          if (nrx < 8) begin
            if (v.lsb) srx[nrx] = mosi;
            else       srx[7-nrx] = mosi;
          end
          nrx++;
        end else begin
          j = v.cpha ? (e - 1) / 2 : e / 2;
          if (j < 8) slave_bit = bit_of(v.slv, v.lsb, j);
        end
      end
      prev_sck = sck; prev_sel = sel_low;
      if (done) begin
        lat = c;
        chk({tag, " rx_data"}, rx_data, v.exp_rx);
        chk({tag, " busy_at_done"}, busy, 1'b0);
        chk({tag, " sck_after"}, sck, v.cpol);
        chk({tag, " ss_at_done"}, ss_n, 3'b111);
        if (chain) begin
          start = 1'b1; ext_loop = 1'b1;
        end
        break;
      end
      @(negedge clk);
    end
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " ss_low_cycles"}, low_cnt, valid ? v.exp_lat - 1 : 0);
    chk({tag, " ss_wrong_bits"}, bad_cnt, 0);
    chk({tag, " sck_rises"}, rises, 8);
    if (valid && !v.ext) chk({tag, " slave_rx"}, srx, v.tx);
  endtask

  initial begin
    vec_t v;
    int c, seen;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst rx_data", rx_data, 8'h00);
    chk("rst sck", sck, 1'b0);
    chk("rst mosi", mosi, 1'b0);
    chk("rst ss_n", ss_n, 3'b111);
    rst = 1'b0;

    tbl[0] = mk(0, 0, 0, 8'd2, 8'hA5, 8'h00, 2'd0, 1, 8'hA5, 37);
    tbl[1] = mk(0, 0, 0, 8'd1, 8'h3C, 8'hC3, 2'd1, 0, 8'hC3, 19);
    tbl[2] = mk(0, 1, 0, 8'd1, 8'h3C, 8'hC3, 2'd2, 0, 8'hC3, 19);
    tbl[3] = mk(1, 0, 0, 8'd1, 8'h3C, 8'hC3, 2'd0, 0, 8'hC3, 19);
    tbl[4] = mk(1, 1, 0, 8'd1, 8'h3C, 8'hC3, 2'd1, 0, 8'hC3, 19);
    tbl[5] = mk(0, 0, 1, 8'd1, 8'h01, 8'h80, 2'd0, 0, 8'h80, 19);
    tbl[6] = mk(0, 0, 0, 8'd0, 8'h96, 8'h69, 2'd2, 0, 8'h69, 19);
    tbl[7] = mk(1, 1, 1, 8'd3, 8'h5A, 8'hE1, 2'd3, 0, 8'h5A, 55);
    tbl[8] = mk(0, 1, 1, 8'd1, 8'hC5, 8'h3A, 2'd1, 0, 8'h3A, 19);
    tbl[9] = mk(1, 0, 0, 8'd2, 8'h6E, 8'hB1, 2'd0, 0, 8'hB1, 37);

    for (int i = 0; i < 8; i++) run_xfer(tbl[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

    run_xfer(tbl[8], 1'b1, 1'b0, "poke");

    // start during the DONE cycle must launch the next transfer immediately
    run_xfer(tbl[9], 1'b0, 1'b1, "chain1");
    @(negedge clk);
    start = 1'b0;
    chk("chain2 busy", busy, 1'b1);
    chk("chain2 ss_n", ss_n, 3'b110);
    c = 1;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("chain2 latency", c, 37);
    chk("chain2 rx_data", rx_data, 8'h6E);

    for (int i = 0; i < 24; i++) begin
      v.cpol = 1'($urandom_range(0, 1)); v.cpha = 1'($urandom_range(0, 1));
      v.lsb = 1'($urandom_range(0, 1)); v.div = 8'($urandom_range(0, 3));
      v.tx = 8'($urandom); v.slv = 8'($urandom); v.sel = 2'($urandom_range(0, 3));
      v.ext = 1'b0;
      run_xfer(model(v), 1'b0, 1'b0, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of XFER aborts without a done pulse
    @(negedge clk);
    ext_loop = 1'b0; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd1;
    tx_data = 8'hF0; ss_sel = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst ss_n", ss_n, 3'b111);
    chk("mid_rst sck", sck, 1'b0);
    chk("mid_rst busy", busy, 1'b0);
    chk("mid_rst rx_data", rx_data, 8'h00);
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("mid_rst no_done", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised SPI master: full-duplex, configurable word width, all four CPOL/CPHA modes, runtime SCK divider, MSB/LSB-first, one-hot selectable active-low slave selects. Sits between a local controller (start/done handshake) and off-chip SPI slaves. Replaces the fixed 8-bit, single-mode, single-slave master.

Parameters:
DATA_W, 8, bits per transfer (>=2)
NUM_SS, 4, number of slave-select outputs (>=1)
DIV_W, 8, width of clk_div input
SS_W, $clog2(NUM_SS) min 1, width of ss_sel (derived, localparam)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  request transfer; accepted only when busy=0
tx_data  in  DATA_W  word to send, latched on accept
ss_sel  in  SS_W  slave index, latched on accept
cpol  in  1  SCK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
lsb_first  in  1  bit order, latched on accept
clk_div  in  DIV_W  SCK half-period in clk cycles (0 treated as 1), latched on accept
busy  out  1  transfer in progress
done  out  1  one-cycle pulse, rx_data valid
rx_data  out  DATA_W  received word, held until next done
sck  out  1  serial clock (registered)
mosi  out  1  serial data out (registered)
miso  in  1  serial data in
ss_n  out  NUM_SS  active-low selects (registered)

Behaviour:
- Reset (rst=1 at clk edge, any state): state=IDLE; busy=0, done=0, rx_data=0, sck=0, mosi=0, ss_n=all 1s; shift/edge/divider counters=0. Mid-transfer reset aborts immediately; no done.
- D = max(clk_div,1). States: IDLE, LEAD, XFER, TRAIL, DONE.
- IDLE: sck loads cpol each cycle; ss_n all 1s. start=1 at cycle T -> latch config, tx_data into shift reg; at T+1: state=LEAD, busy=1, ss_n[ss_sel]=0, mosi=first bit (tx MSB or LSB per lsb_first).
- LEAD: D cycles (SS setup), sck=cpol. Then XFER.
- XFER: sck toggles every D cycles, 2*DATA_W edges total, numbered 1..2*DATA_W.
  cpha=0: sample miso on odd edges; mosi advances on even edges 2..2*DATA_W-2.
  cpha=1: sample miso on even edges; mosi advances on odd edges 3..2*DATA_W-1.
  Samples shift into rx shift reg in the same bit order as transmit.
- After edge 2*DATA_W: TRAIL for D cycles (sck=cpol, SS hold), then DONE.
- DONE (one cycle): ss_n all 1s, busy=0, done=1, rx_data updated. Returns to IDLE. Transfer total: done at T+1+D*(2*DATA_W+2).
- start while busy=1: ignored, no queuing. start in DONE cycle: accepted (busy=0).
- ss_sel >= NUM_SS: transfer runs, no ss_n asserted, rx still captured.
- Config inputs changing mid-transfer: no effect (latched copies used).
- Counters: edge counter width $clog2(2*DATA_W+1); divider counter DIV_W bits, reload to D-1, no wrap issues.

Optional Feature:
SPI_LOOPBACK_EN: defined -> extra input port loopback (1 bit, after miso); when loopback=1 sampled data is internal mosi and miso is ignored, ss_n still asserted normally. Undefined -> port absent, miso always used.

Decomposition:
Package spi_pkg: state enum (IDLE, LEAD, XFER, TRAIL, DONE), function for edge-counter width. One natural sub-module: spi_clk_gen (divider counter, tick output every D cycles, sck toggle/idle level) instantiated by spi_master_param; shift/FSM stay in top.

Test Plan:
- Mode 0, DATA_W=8, D=2, tx=0xA5, slave loops miso=mosi externally -> rx_data=0xA5, done at T+37, ss_n[ss_sel] low for exactly 36 cycles, 8 rising sck edges.
- All 4 modes, D=1, tx=0x3C, slave model driving 0xC3 per mode -> rx_data=0xC3 each mode; sck idle=cpol before/after.
- lsb_first=1, tx=0x01 -> first mosi bit 1, remaining 0; slave sends 0x80 LSB-first -> rx_data=0x80.
- clk_div=0 vs 1 -> identical timing (D=1), done at T+19.
- start pulsed during busy and config changed mid-transfer -> no restart, result unaffected; start in done cycle -> next transfer begins next cycle.
- rst asserted mid-XFER -> next cycle ss_n=all 1s, sck=0, busy=0, no done pulse; ss_sel=NUM_SS -> no ss_n low, done still pulses.
